// File: rtl/kypd_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package kypd_pkg;

    // Debounce states, evaluated once per completed scan
    typedef enum logic [1:0] {
        IDLE,
        PRESS_CHK,
        HELD,
        REL_CHK
    } kypd_state_e;

    // Result of one column sample or one full scan; valid=0 encodes NONE
    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } scan_res_t;

    localparam scan_res_t RES_NONE = '{valid: 1'b0, code: 4'h0};

    // Hex code per key, indexed by {col[1:0], row[1:0]}; entry 0 is the rightmost
    localparam logic [15:0][3:0] KEY_MAP = {
        4'hD, 4'hC, 4'hB, 4'hA,   // col 3, rows 3..0
        4'hE, 4'h9, 4'h6, 4'h3,   // col 2, rows 3..0
        4'hF, 4'h8, 4'h5, 4'h2,   // col 1, rows 3..0
        4'h0, 4'h7, 4'h4, 4'h1    // col 0, rows 3..0
    };

    function automatic logic [3:0] key_lookup(input logic [1:0] col_idx,
                                              input logic [1:0] row_idx);
        return KEY_MAP[{col_idx, row_idx}];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for slow asynchronous level inputs (rows, switches, buttons).
module sync_2ff #(
    parameter int unsigned     WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two-stage capture; reset value chosen by the user (idle level of the input)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/kypd_scan.sv
// 4x4 keypad scanner: column strobe, per-scan priority pick, scan-level debounce.
module kypd_scan
    import kypd_pkg::*;
#(
    parameter int unsigned SCAN_COUNT     = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clock,
    input  logic       reset,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key,
    output logic       key_valid,
    output logic       key_down,
    output logic [5:0] digit
);

    localparam int unsigned     TW         = (SCAN_COUNT > 2) ? $clog2(SCAN_COUNT) : 1;
    localparam int unsigned     CW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(SCAN_COUNT - 1);
    localparam logic [CW-1:0]   CNT_DONE   = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

    logic [3:0]    row_s;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    col_q, col_d;
    logic [1:0]    col_idx_q, col_idx_d;
    scan_res_t     acc_q, acc_d;
    scan_res_t     sample_res;
    scan_res_t     scan_res;
    logic          tc;
    logic          scan_end;

    kypd_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [3:0]    cand_q;
    logic [3:0]    key_q;
    logic          key_valid_q;
    logic          key_down_q;
    logic          key_seen_q;

    sync_2ff #(
        .WIDTH    (4),
        .RESET_VAL(4'hF)
    ) u_row_sync (
        .clock(clock),
        .reset(reset),
        .d_i  (row),
        .q_o  (row_s)
    );

    // Lowest active row in the driven column wins
    always_comb begin
        sample_res = RES_NONE;
        for (int r = 3; r >= 0; r--) begin
            if (!row_s[r]) begin
                sample_res = '{valid: 1'b1, code: key_lookup(col_idx_q, 2'(r))};
            end
        end
    end

    // Column timer, rotator and scan accumulator next-state
    always_comb begin
        tc        = (timer_q == TIMER_LAST);
        scan_end  = tc && (col_idx_q == 2'd3);
        scan_res  = acc_q.valid ? acc_q : sample_res;
        timer_d   = tc ? '0 : timer_q + TW'(1);
        col_d     = col_q;
        col_idx_d = col_idx_q;
        acc_d     = acc_q;
        if (tc) begin
            col_d     = {col_q[2:0], col_q[3]};
            col_idx_d = col_idx_q + 2'd1;
            acc_d     = scan_end ? RES_NONE : scan_res;
        end
    end

    // Scan datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer_q   <= '0;
            col_q     <= 4'b1110;
            col_idx_q <= 2'd0;
            acc_q     <= RES_NONE;
        end else begin
            timer_q   <= timer_d;
            col_q     <= col_d;
            col_idx_q <= col_idx_d;
            acc_q     <= acc_d;
        end
    end

    // Debounce FSM and registered key outputs, advanced once per scan end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            key_down_q  <= 1'b0;
            key_seen_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_end) begin
                case (state_q)
                    IDLE: begin
                        if (scan_res.valid) begin
                            cand_q <= scan_res.code;
                            if (DEBOUNCE_SCANS == 1) begin
                                key_q       <= scan_res.code;
                                key_valid_q <= 1'b1;
                                key_down_q  <= 1'b1;
                                key_seen_q  <= 1'b1;
                                state_q     <= HELD;
                                cnt_q       <= '0;
                            end else begin
                                state_q <= PRESS_CHK;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    PRESS_CHK: begin
                        if (!scan_res.valid) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (scan_res.code != cand_q) begin
                            cand_q <= scan_res.code;
                            cnt_q  <= CNT_ONE;
                        end else if (cnt_q + CW'(1) == CNT_DONE) begin
                            key_q       <= cand_q;
                            key_valid_q <= 1'b1;
                            key_down_q  <= 1'b1;
                            key_seen_q  <= 1'b1;
                            state_q     <= HELD;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    HELD: begin
                        if (!scan_res.valid) begin
                            if (DEBOUNCE_SCANS == 1) begin
                                key_down_q <= 1'b0;
                                state_q    <= IDLE;
                                cnt_q      <= '0;
                            end else begin
                                state_q <= REL_CHK;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    REL_CHK: begin
                        if (scan_res.valid) begin
                            state_q <= HELD;
                            cnt_q   <= '0;
                        end else if (cnt_q + CW'(1) == CNT_DONE) begin
                            key_down_q <= 1'b0;
                            state_q    <= IDLE;
                            cnt_q      <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign col       = col_q;
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign key_down  = key_down_q;
    assign digit     = {key_seen_q, key_q, 1'b0};

endmodule

// File: tb/tb_kypd_scan.sv
// Scoreboard bench for kypd_scan with a modelled 4x4 keypad.
module tb_kypd_scan;

    localparam int unsigned SCAN_COUNT     = 4;
    localparam int unsigned DEBOUNCE_SCANS = 2;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key;
    logic       key_valid;
    logic       key_down;
    logic [5:0] digit;

    logic [3:0] pressed [4];
    logic [3:0] exp_q [$];
    logic [3:0] exp_key;
    logic       prev_kv = 1'b0;
    int         checks  = 0;
    int         errors  = 0;
    int         evt_cnt = 0;

    kypd_scan #(
        .SCAN_COUNT    (SCAN_COUNT),
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .col      (col),
        .row      (row),
        .key      (key),
        .key_valid(key_valid),
        .key_down (key_down),
        .digit    (digit)
    );

    always #5 clock = ~clock;

    // Keypad model: a pressed key pulls its row low while its column is driven
    always_comb begin
        row = 4'hF;
        for (int c = 0; c < 4; c++) begin
            if (!col[c]) row = row & ~pressed[c];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Event monitor: pops the scoreboard on every key_valid pulse
    always @(negedge clock) begin
        if (key_valid === 1'b1) begin
            chk("kv_width", 32'(prev_kv), 32'h0);
            evt_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexpected_event", 32'(exp_q.size()), 32'h1);
            end else begin
                exp_key = exp_q.pop_front();
                chk("event_key", 32'(key), 32'(exp_key));
                chk("event_digit", 32'(digit), 32'({1'b1, exp_key, 1'b0}));
                chk("event_key_down", 32'(key_down), 32'h1);
            end
        end
        prev_kv = key_valid;
    end

    task automatic clear_keys();
        for (int c = 0; c < 4; c++) pressed[c] = 4'h0;
    endtask

    task automatic press(input int c, input int r);
        pressed[c][r] = 1'b1;
    endtask

    // Returns just after the edge where col wraps 0111 -> 1110 (scan boundary)
    task automatic wait_scan_start();
        logic [3:0] prev;
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            prev = col;
            @(posedge clock);
            #1;
            if (prev == 4'b0111 && col == 4'b1110) got = 1'b1;
        end
        chk("scan_boundary", 32'(got), 32'h1);
    endtask

    task automatic scans(input int n);
        for (int i = 0; i < n; i++) wait_scan_start();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] exp_col;
        reset = 1'b1;
        clear_keys();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_col", 32'(col), 32'hE);
        chk("rst_key", 32'(key), 32'h0);
        chk("rst_kv", 32'(key_valid), 32'h0);
        chk("rst_kd", 32'(key_down), 32'h0);
        chk("rst_digit", 32'(digit), 32'h0);

        // Idle: column rotation every SCAN_COUNT cycles, no activity
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 100; k++) begin
            exp_col = ~(4'b0001 << 2'((k / 4) % 4));
            chk("idle_col", 32'(col), 32'(exp_col));
            chk("idle_kv_kd", 32'({key_valid, key_down}), 32'h0);
            @(negedge clock);
        end
        chk("idle_digit", 32'(digit), 32'h0);
        chk("idle_events", 32'(evt_cnt), 32'h0);

        // Hold 9 (c2/r2), then release
        wait_scan_start();
        press(2, 2);
        exp_q.push_back(4'h9);
        scans(1);
        chk("s9_early_down", 32'(key_down), 32'h0);
        scans(1);
        chk("s9_key", 32'(key), 32'h9);
        chk("s9_down", 32'(key_down), 32'h1);
        chk("s9_digit", 32'(digit), 32'b110010);
        clear_keys();
        scans(1);
        chk("s9_rel_pending", 32'(key_down), 32'h1);
        scans(1);
        chk("s9_released", 32'(key_down), 32'h0);
        chk("s9_key_kept", 32'(key), 32'h9);

        // Bounce on 5: 1 scan press, 1 scan none, 2 scans press
        press(1, 1);
        scans(1);
        clear_keys();
        scans(1);
        press(1, 1);
        exp_q.push_back(4'h5);
        scans(1);
        chk("s5_no_early_kv", 32'(key_valid), 32'h0);
        chk("s5_no_early_kd", 32'(key_down), 32'h0);
        scans(1);
        chk("s5_key", 32'(key), 32'h5);
        chk("s5_down", 32'(key_down), 32'h1);
        clear_keys();
        scans(2);
        chk("s5_released", 32'(key_down), 32'h0);

        // Simultaneous 4 (c0/r1) and 2 (c1/r0): scan order picks 4
        press(0, 1);
        press(1, 0);
        exp_q.push_back(4'h4);
        scans(2);
        chk("s4_key", 32'(key), 32'h4);
        clear_keys();
        scans(2);
        chk("s4_released", 32'(key_down), 32'h0);

        // Hold A, slide to B without release, release, then press B
        press(3, 0);
        exp_q.push_back(4'hA);
        scans(2);
        chk("sA_key", 32'(key), 32'hA);
        clear_keys();
        press(3, 1);
        scans(3);
        chk("sAB_key_kept", 32'(key), 32'hA);
        chk("sAB_down", 32'(key_down), 32'h1);
        clear_keys();
        scans(2);
        chk("sAB_released", 32'(key_down), 32'h0);
        press(3, 1);
        exp_q.push_back(4'hB);
        scans(2);
        chk("sB_key", 32'(key), 32'hB);
        chk("sB_digit", 32'(digit), 32'({1'b1, 4'hB, 1'b0}));
        clear_keys();
        scans(2);

        // Reset during PRESS_CHK with 7 held; fresh event after 2 scans
        press(0, 2);
        scans(1);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_col", 32'(col), 32'hE);
        chk("mid_rst_key", 32'(key), 32'h0);
        chk("mid_rst_kv", 32'(key_valid), 32'h0);
        chk("mid_rst_kd", 32'(key_down), 32'h0);
        chk("mid_rst_digit", 32'(digit), 32'h0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        exp_q.push_back(4'h7);
        scans(1);
        chk("s7_no_early_kv", 32'(key_valid), 32'h0);
        chk("s7_no_early_kd", 32'(key_down), 32'h0);
        scans(1);
        chk("s7_key", 32'(key), 32'h7);
        chk("s7_down", 32'(key_down), 32'h1);
        chk("s7_digit", 32'(digit), 32'({1'b1, 4'h7, 1'b0}));
        clear_keys();
        scans(2);
        chk("s7_released", 32'(key_down), 32'h0);

        @(negedge clock);
        @(negedge clock);
        chk("sb_pending", 32'(exp_q.size()), 32'h0);
        chk("event_total", 32'(evt_cnt), 32'd6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kypd_scan.md
# kypd_scan

Scanner for a 4x4 matrix keypad on a Pmod header, the input-side counterpart of the board's multiplexed 7-segment display driver. It strobes one column at a time, samples the rows, debounces across whole scans, and reports one event per debounced key press. It also outputs the key as a 6-bit digit word `{en, hex[3:0], dp}`, which the display driver's digit inputs accept directly.

## Interface
- `SCAN_COUNT`, default 50000: clock cycles each column stays driven. The default gives 0.5 ms at 100 MHz. Minimum 4.
- `DEBOUNCE_SCANS`, default 4: number of consecutive identical full-scan results needed to accept a press or a release. Minimum 1.
- `clock`  in  1: system clock.
- `reset`  in  1: reset, asynchronous, active-high.
- `col`  out  4: column drive, active-low, exactly one bit low at any time.
- `row`  in  4: row sense, active-low (externally pulled up), asynchronous to `clock`.
- `key`  out  4: hex code of the last accepted key.
- `key_valid`  out  1: one-cycle pulse when a press is accepted.
- `key_down`  out  1: high from acceptance until the release is accepted.
- `digit`  out  6: `{key_seen, key, 1'b0}`. `key_seen` is 1 once any key has been accepted since reset.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- Column timer counts 0..SCAN_COUNT-1. At terminal count:
  - the synchronized rows for the current column are sampled;
  - `col` rotates low-bit order: 1110 → 1101 → 1011 → 0111 → 1110.
- One full scan is 4 column periods and ends when column 3 is sampled.
- Scan result: the first active key in scan order (column 0 first; within a column, row 0 first), or NONE. Other keys pressed at the same time are ignored.
- Key map, listed as column c : rows 0..3:
  - c0: 1, 4, 7, 0
  - c1: 2, 5, 8, F
  - c2: 3, 6, 9, E
  - c3: A, B, C, D
- Debounce state machine (states IDLE, PRESS_CHK, HELD, REL_CHK), evaluated once per scan end:
  - IDLE: result K → PRESS_CHK with cand=K, cnt=1. If DEBOUNCE_SCANS=1, accept immediately.
  - PRESS_CHK:
    - result equals cand → cnt+1. When cnt reaches DEBOUNCE_SCANS, accept and go to HELD.
    - result is a different key → restart with the new cand, cnt=1.
    - result is NONE → IDLE.
  - Accept means: `key`←cand, `key_valid` pulses, `key_down`←1, `key_seen`←1.
  - HELD: result NONE → REL_CHK with cnt=1 (DEBOUNCE_SCANS=1 releases immediately). Any key, including a different one, stays in HELD. A key change without a release produces no event.
  - REL_CHK:
    - NONE → cnt+1. At DEBOUNCE_SCANS: `key_down`←0, go to IDLE.
    - any key → back to HELD, no new event.
- `key` holds its value after release. It changes only on acceptance.

## Timing
- Reset values:
  - `col`=1110, timer=0, state IDLE, cnt=0;
  - `key`=0, `key_valid`=0, `key_down`=0, `digit`=000000;
  - synchronizer flops all 1s (no press).
- After reset, the first column sample occurs at cycle SCAN_COUNT-1.
- Sync latency is 2 cycles. Because sampling happens at the end of a column period, rows have settled for at least SCAN_COUNT-2 cycles.
- `key_valid`, `key_down`, `key` and `digit` update on the clock edge after the final scan end that completes the debounce. All outputs are registered.
- Press-to-event latency is at most (DEBOUNCE_SCANS+1)·4·SCAN_COUNT + 3 cycles.
- `key_valid` is never high for more than 1 cycle. At most one pulse per press/release pair.
- Reset asserted mid-scan or mid-debounce returns everything to reset values immediately. No event is emitted.

## Structure
- Shared package `kypd_pkg`:
  - state enum (IDLE, PRESS_CHK, HELD, REL_CHK);
  - 16-entry key-map constant indexed by {col, row};
  - NONE encoding (valid bit plus 4-bit code).
- Sub-module `sync_2ff`, 4 bits wide, for `row`. Reusable for switches and buttons.
- Timer, column rotator, scan accumulator and FSM all live in `kypd_scan`.

## Test plan
All scenarios use SCAN_COUNT=4, DEBOUNCE_SCANS=2. The bench models the keypad as row = ~(pressed keys in the currently driven column).
- Reset, then idle for 100 cycles → `col` cycles 1110, 1101, 1011, 0111 every 4 cycles; `key_valid` and `key_down` stay 0; `digit`=000000.
- Hold key at c2/r2 → after 2 clean scans: single `key_valid`, `key`=9, `digit`=6'b110010, `key_down`=1. Release for 2 scans → `key_down`=0, `key` stays 9.
- Bounce: press 5 for 1 scan, NONE for 1 scan, press 5 for 2 scans → exactly one event, `key`=5, and it arrives only after the final two scans.
- Simultaneous press of 4 (c0/r1) and 2 (c1/r0) → `key`=4.
- Hold A, then switch to B without a release → no second pulse. Release, then press B → second pulse with `key`=B.
- Assert reset during PRESS_CHK with key 7 held, then release reset with the key still held → outputs at reset values; a fresh event arrives after 2 full scans.
